// File: rtl/ex_compute_unit.sv
// RV32IM execute-stage compute: ALU + optional RV32M multiplier (EXU_MUL_EN), result mux, zero flag.
// Latency 1 cycle with REG_OUT=1 (0 with REG_OUT=0); one op per cycle, never stalls, no back-pressure.
module ex_compute_unit #(
  parameter int unsigned REG_OUT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [3:0]  alu_op,
  input  logic        alu_src,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [31:0] immediate,
  output logic [31:0] result_o,
  output logic        zero_o,
  output logic        valid_o
);

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_SLL    = 4'd2;
  localparam logic [3:0] OP_SLT    = 4'd3;
  localparam logic [3:0] OP_SLTU   = 4'd4;
  localparam logic [3:0] OP_XOR    = 4'd5;
  localparam logic [3:0] OP_SRL    = 4'd6;
  localparam logic [3:0] OP_SRA    = 4'd7;
  localparam logic [3:0] OP_OR     = 4'd8;
  localparam logic [3:0] OP_AND    = 4'd9;
  localparam logic [3:0] OP_MUL    = 4'd10;
  localparam logic [3:0] OP_MULH   = 4'd11;
  localparam logic [3:0] OP_MULHSU = 4'd12;
  localparam logic [3:0] OP_MULHU  = 4'd13;
  localparam logic [3:0] OP_PASSB  = 4'd14;

  logic [31:0] w_alu_b;
  logic [4:0]  w_shamt;
  logic [31:0] w_alu_result;
  logic [31:0] w_mul_result;
  logic        w_is_mul;
  logic [31:0] w_final;
  logic        w_zero;

  assign w_alu_b = alu_src ? immediate : operand_b;
  assign w_shamt = w_alu_b[4:0];

  // Multiply codes and the reserved code fall through to 0 here.
  always_comb begin
    w_alu_result = 32'h0;
    case (alu_op)
      OP_ADD:   w_alu_result = operand_a + w_alu_b;
      OP_SUB:   w_alu_result = operand_a - w_alu_b;
      OP_SLL:   w_alu_result = operand_a << w_shamt;
      OP_SLT:   w_alu_result = {31'h0, $signed(operand_a) < $signed(w_alu_b)};
      OP_SLTU:  w_alu_result = {31'h0, operand_a < w_alu_b};
      OP_XOR:   w_alu_result = operand_a ^ w_alu_b;
      OP_SRL:   w_alu_result = operand_a >> w_shamt;
      OP_SRA:   w_alu_result = $unsigned($signed(operand_a) >>> w_shamt);
      OP_OR:    w_alu_result = operand_a | w_alu_b;
      OP_AND:   w_alu_result = operand_a & w_alu_b;
      OP_PASSB: w_alu_result = w_alu_b;
      default:  w_alu_result = 32'h0;
    endcase
  end

`ifdef EXU_MUL_EN
  logic        w_a_signed;
  logic        w_b_signed;
  logic [63:0] w_mul_a;
  logic [63:0] w_mul_b;
  logic [63:0] w_prod;

  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    case (alu_op)
      OP_MULH: begin
        w_a_signed = 1'b1;
        w_b_signed = 1'b1;
      end
      OP_MULHSU: w_a_signed = 1'b1;
      default: begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
      end
    endcase
  end

  // Extending to 64 bits makes the truncated unsigned product exact for all signedness mixes.
  assign w_mul_a = {{32{w_a_signed & operand_a[31]}}, operand_a};
  assign w_mul_b = {{32{w_b_signed & operand_b[31]}}, operand_b};
  assign w_prod  = w_mul_a * w_mul_b;

  always_comb begin
    w_mul_result = 32'h0;
    case (alu_op)
      OP_MUL:                       w_mul_result = w_prod[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_mul_result = w_prod[63:32];
      default:                      w_mul_result = 32'h0;
    endcase
  end
`else
  assign w_mul_result = 32'h0;
`endif

  assign w_is_mul = (alu_op >= OP_MUL) && (alu_op <= OP_MULHU);
  assign w_final  = w_is_mul ? w_mul_result : w_alu_result;
  assign w_zero   = (w_final == 32'h0);

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [31:0] r_result;
      logic        r_zero;
      logic        r_valid;

      // Updates every cycle; consumers must qualify result_o with valid_o.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_result <= 32'h0;
          r_zero   <= 1'b1;
          r_valid  <= 1'b0;
        end else begin
          r_result <= w_final;
          r_zero   <= w_zero;
          r_valid  <= valid_i;
        end
      end

      assign result_o = r_result;
      assign zero_o   = r_zero;
      assign valid_o  = r_valid;
    end else begin : g_comb_out
      logic w_unused_clk_rst;
      assign w_unused_clk_rst = clk ^ rst;
      assign result_o = w_final;
      assign zero_o   = w_zero;
      assign valid_o  = valid_i;
    end
  endgenerate

endmodule

// File: tb/tb_ex_compute_unit.sv
// Directed bench for ex_compute_unit with REG_OUT=1; multiply expectations follow EXU_MUL_EN.
module tb_ex_compute_unit;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [3:0]  alu_op;
  logic        alu_src;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] immediate;
  logic [31:0] result_o;
  logic        zero_o;
  logic        valid_o;

  int n_checks;
  int n_pass;

`ifdef EXU_MUL_EN
  localparam logic [31:0] E_MULH   = 32'h4000_0000;
  localparam logic [31:0] E_MULHU  = 32'hFFFF_FFFE;
  localparam logic [31:0] E_MULHSU = 32'hFFFF_FFFF;
  localparam logic [31:0] E_MUL37  = 32'h0000_0015;
`else
  localparam logic [31:0] E_MULH   = 32'h0;
  localparam logic [31:0] E_MULHU  = 32'h0;
  localparam logic [31:0] E_MULHSU = 32'h0;
  localparam logic [31:0] E_MUL37  = 32'h0;
`endif

  ex_compute_unit #(.REG_OUT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (valid_i),
    .alu_op    (alu_op),
    .alu_src   (alu_src),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .immediate (immediate),
    .result_o  (result_o),
    .zero_o    (zero_o),
    .valid_o   (valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [31:0] res, input logic z, input logic v);
    chk({tag, ".result"}, result_o, res);
    chk({tag, ".zero"},   {31'h0, zero_o},  {31'h0, z});
    chk({tag, ".valid"},  {31'h0, valid_o}, {31'h0, v});
  endtask

  // Drive one op, then land #1 after the edge that samples it.
  task automatic issue(input logic [3:0] op, input logic src, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic v);
    alu_op    = op;
    alu_src   = src;
    operand_a = a;
    operand_b = b;
    immediate = imm;
    valid_i   = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b0;
    valid_i   = 1'b0;
    alu_op    = 4'd0;
    alu_src   = 1'b0;
    operand_a = 32'h0;
    operand_b = 32'h0;
    immediate = 32'h0;

    #1 rst = 1'b1;
    #1 chk_out("reset", 32'h0, 1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;

    issue(4'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    chk_out("idle_after_reset", 32'h0, 1'b1, 1'b0);

    issue(4'd1, 1'b0, 32'h0000_0010, 32'h0000_0003, 32'h0, 1'b1);
    chk_out("sub", 32'h0000_000D, 1'b0, 1'b1);
    issue(4'd0, 1'b1, 32'h5, 32'h5, 32'hFFFF_FFFB, 1'b1);
    chk_out("add_imm_wrap", 32'h0, 1'b1, 1'b1);

    issue(4'd3, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1);
    chk_out("slt", 32'h1, 1'b0, 1'b1);
    issue(4'd4, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1);
    chk_out("sltu", 32'h0, 1'b1, 1'b1);
    issue(4'd7, 1'b0, 32'h8000_0000, 32'h24, 32'h0, 1'b1);
    chk_out("sra", 32'hF800_0000, 1'b0, 1'b1);
    issue(4'd6, 1'b0, 32'h8000_0000, 32'h24, 32'h0, 1'b1);
    chk_out("srl", 32'h0800_0000, 1'b0, 1'b1);
    issue(4'd2, 1'b1, 32'h0000_0001, 32'h0, 32'hFFFF_FFE1, 1'b1);
    chk_out("sll_imm", 32'h0000_0002, 1'b0, 1'b1);
    issue(4'd14, 1'b1, 32'hDEAD_BEEF, 32'h1, 32'h1234_5000, 1'b1);
    chk_out("pass_b", 32'h1234_5000, 1'b0, 1'b1);
    issue(4'd15, 1'b0, 32'h1, 32'h2, 32'h0, 1'b1);
    chk_out("reserved", 32'h0, 1'b1, 1'b1);

    issue(4'd11, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678, 1'b1);
    chk_out("mulh", E_MULH, E_MULH == 32'h0, 1'b1);
    issue(4'd13, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    chk_out("mulhu", E_MULHU, E_MULHU == 32'h0, 1'b1);
    issue(4'd12, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    chk_out("mulhsu", E_MULHSU, E_MULHSU == 32'h0, 1'b1);
    issue(4'd10, 1'b1, 32'h0001_0000, 32'h0001_0000, 32'h1234_5678, 1'b1);
    chk_out("mul_low_zero", 32'h0, 1'b1, 1'b1);

    issue(4'd0, 1'b0, 32'h0000_0100, 32'h0000_0023, 32'h0, 1'b1);
    chk_out("pipe_add", 32'h0000_0123, 1'b0, 1'b1);
    issue(4'd10, 1'b1, 32'h3, 32'h7, 32'h1234_5678, 1'b1);
    chk_out("pipe_mul", E_MUL37, E_MUL37 == 32'h0, 1'b1);
    issue(4'd5, 1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0, 1'b1);
    chk_out("pipe_xor", 32'hF0F0_F0F0, 1'b0, 1'b1);
    issue(4'd8, 1'b0, 32'h0000_00A0, 32'h0000_000A, 32'h0, 1'b0);
    chk_out("pipe_bubble", 32'h0000_00AA, 1'b0, 1'b0);
    issue(4'd9, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0, 1'b1);
    chk_out("pipe_and", 32'h0000_F000, 1'b0, 1'b1);

    // Async reset between edges while a valid result is on the outputs.
    alu_op    = 4'd0;
    operand_a = 32'h1;
    operand_b = 32'h2;
    valid_i   = 1'b1;
    #2 rst = 1'b1;
    #1 chk_out("mid_reset", 32'h0, 1'b1, 1'b0);
    @(posedge clk);
    #1 chk_out("held_reset", 32'h0, 1'b1, 1'b0);
    #2 rst = 1'b0;
    issue(4'd0, 1'b0, 32'h0000_0040, 32'h0000_0002, 32'h0, 1'b1);
    chk_out("after_reset", 32'h0000_0042, 1'b0, 1'b1);
    issue(4'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    chk_out("drain", 32'h0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_compute_unit.md
Name: ex_compute_unit

Overview:
- Execute-stage compute block of the RV32IM pipeline.
- Combines three parts:
  - an integer ALU;
  - an RV32M multiplier (MUL/MULH/MULHSU/MULHU);
  - a result mux that selects ALU or multiplier output by opcode.
- The result, zero flag and valid are registered once before being handed to the EX/MEM boundary.

Parameters:
- REG_OUT, 1, 1 = outputs registered (1-cycle latency); 0 = outputs combinational, and the clk/rst register stage is bypassed.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- valid_i  input  1  operands/opcode valid this cycle.
- alu_op  input  4  operation code (encoding below).
- alu_src  input  1  1 = ALU operand B is immediate; 0 = operand_b.
- operand_a  input  32  forwarded rs1 value.
- operand_b  input  32  forwarded rs2 value.
- immediate  input  32  sign-extended immediate.
- result_o  output  32  selected result.
- zero_o  output  1  1 when result_o == 0.
- valid_o  output  1  result_o/zero_o valid.

Behaviour:
- alu_op encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU
  - 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
  - 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU
  - 14 PASS_B, 15 reserved
- ALU operand B: B = alu_src ? immediate : operand_b.
- ALU arithmetic:
  - ADD/SUB wrap modulo 2^32.
  - SLT is a signed compare and SLTU an unsigned compare; both return 32'h1 or 32'h0.
  - Shifts use B[4:0] only; SRA replicates bit 31.
  - PASS_B returns B (used for LUI).
  - Reserved code 15 returns 0.
- Multiplier operands: operand_a and operand_b always; alu_src and immediate are ignored.
  - MUL: low 32 bits of the product.
  - MULH: high 32 bits of signed×signed.
  - MULHSU: high 32 bits of signed(a)×unsigned(b).
  - MULHU: high 32 bits of unsigned×unsigned.
  - The product is a full 64-bit combinational product.
  - For non-mul codes the multiplier output is 0.
- Mux: final = (alu_op in 10..13) ? mul_result : alu_result.
- Zero flag: zero = (final == 32'h0). It is computed for every op, including multiply ops.
- REG_OUT=1:
  - On each rising clk, result_o <= final, zero_o <= zero, valid_o <= valid_i.
  - Latency is one cycle and throughput one op per cycle, with no stall or back-pressure.
  - The output register updates every cycle regardless of valid_i, so downstream logic must qualify result_o with valid_o.
- Reset:
  - While rst=1, asynchronously: result_o=0, zero_o=1, valid_o=0.
  - Reset asserted mid-operation discards the in-flight result.
  - The first valid_o after deassertion appears one clock after the first sampled valid_i=1.
- REG_OUT=0: outputs follow the inputs combinationally; rst is unused.
- X handling: no latches; every alu_op code drives a defined value.

Optional Feature:
- Macro: EXU_MUL_EN.
- Defined: the multiplier is instantiated, and codes 10–13 behave as above.
- Undefined:
  - the multiplier logic is omitted;
  - codes 10–13 produce final = 0 (zero = 1);
  - all other codes are unchanged.

Test Plan:
- Basic ALU, REG_OUT=1, valid_i=1:
  - SUB a=0x00000010, b=0x00000003, alu_src=0 → next cycle result_o=0x0000000D, zero_o=0, valid_o=1.
  - ADD a=5, b=5, immediate=0xFFFFFFFB, alu_src=1 → result_o=0x00000000, zero_o=1. Confirms immediate selection and wrap.
- Compares and shifts:
  - SLT a=0xFFFFFFFF, b=1 → 0x1.
  - SLTU with same operands → 0x0.
  - SRA a=0x80000000, b=0x24 (shamt 4) → 0xF8000000.
  - SRL with same operands → 0x08000000.
- Multiply (EXU_MUL_EN defined), alu_src=1 with immediate=0x12345678 to prove the immediate is ignored:
  - MULH a=b=0x80000000 → 0x40000000.
  - MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF.
  - MUL a=0x00010000, b=0x00010000 → 0x00000000 with zero_o=1.
- Pipelining: issue ADD, MUL, XOR on three consecutive cycles.
  - Results appear on three consecutive cycles in order.
  - valid_o tracks valid_i delayed by one cycle, including a single valid_i=0 bubble.
- Reset mid-stream: assert rst asynchronously between clock edges while valid_o=1.
  - Immediately result_o=0, zero_o=1, valid_o=0.
  - After release, the next op returns normally.
- Build without EXU_MUL_EN: MULHU a=b=0xFFFFFFFF → result_o=0, zero_o=1. Code 15 → 0 in both builds.
